settings_menu_ctrl: RTL and testbench
=====================================

// Module: settings_menu_ctrl
// PURPOSE
// Complete controller for a multi-option settings menu. Holds up/down hover navigation,
// per-option choice selection with hold-to-repeat, and commit/cancel of the edited set.
// Sits between the keypad decoder and the game core. The game core sees only committed
// choices. The menu renderer queries the highlight colour per option row.
// PARAMETERS
// NUM_OPTIONS   8             number of option rows (2..8)
// CW            3             bits per choice index; max choices per option = 2**CW
// NUM_CHOICES   {8{3'd1}}     packed NUM_OPTIONS*CW; field i = (choice count of option i) - 1
// WRAP          1             1: choice/hover wrap at ends; 0: saturate at ends
// REPEAT_DELAY  25_000_000    cycles a key is held before the first auto-repeat (>=2)
// REPEAT_RATE   5_000_000     cycles between later auto-repeats (>=1)
// PORTS
// clk             in   1              system clock
// resetN          in   1              synchronous active-low reset
// enable          in   1              menu shown; when low, keys are ignored and FSM -> IDLE
// key_is_pressed  in   10             keypad level: [8]=up [2]=down [4]=left [6]=right [5]=enter [0]=cancel
// row_idx         in   3              option row being drawn (renderer query)
// hovered_idx     out  3              currently hovered option
// work_choices    out  NUM_OPTIONS*CW edited (uncommitted) choices, field i = option i
// cmt_choices     out  NUM_OPTIONS*CW committed choices fed to game core
// commit_pulse    out  1              1-cycle pulse when cmt_choices updates
// cancel_pulse    out  1              1-cycle pulse when edits are discarded
// rgb             out  8              `BLUE if row_idx==hovered_idx, else `WHITE (combinational)
// BEHAVIOUR
// - Reset (resetN low at posedge): FSM=IDLE. hovered_idx=0. work/cmt_choices all 0.
//   Pulses=0. Repeat counter=0. Key history=0.
// - FSM states: IDLE, BROWSE, HOLD. IDLE->BROWSE when enable=1. Any state->IDLE when enable=0.
//   On IDLE entry, work_choices is reloaded from cmt_choices.
// - Direction key: the highest-priority pressed key among up>down>left>right.
//   When the direction key changes, the new key is treated as a fresh press.
// - BROWSE: a rising edge of the direction key is one "step" in that cycle.
//   The FSM then goes to HOLD, and the counter loads REPEAT_DELAY-1.
// - HOLD: the counter decrements each cycle while the same key is held.
//   At 0, one step is produced and the counter reloads REPEAT_RATE-1.
//   Key released or changed -> BROWSE, in the same cycle.
// - Step up/down: hovered_idx -/+ 1 over 0..NUM_OPTIONS-1. Wraps or saturates per WRAP.
// - Step left/right: work field[hovered_idx] -/+ 1 over 0..NUM_CHOICES[hovered_idx].
//   Wraps or saturates per WRAP. Field compare uses full CW width. No other field changes.
// - Results of a step are registered: outputs change 1 cycle after the step cycle.
// - Enter rising edge (BROWSE or HOLD): cmt_choices<=work_choices; commit_pulse=1 for 1 cycle.
// - Cancel rising edge: work_choices<=cmt_choices; cancel_pulse=1 for 1 cycle.
// - Enter and cancel edges in the same cycle: cancel wins, no commit.
// - Enter/cancel edge together with a step: the step is dropped that cycle.
// - Enter/cancel edge together with a step: hover is unaffected by enter/cancel.
// - Key history updates every cycle, including in IDLE. A key already held when enable
//   rises produces no edge.
// - Option with count field 0 (one choice): left/right leave it 0 and produce no pulse.
// - Reset mid-hold: the counter is cleared and no stale repeat fires after reset.
// TESTING
// - Reset, enable=1, tap down x3 (1 cycle each) -> hovered_idx=3; rgb=`BLUE only for row_idx=3.
// - WRAP=1, hovered=0, tap up -> hovered_idx=7. WRAP=0, same stimulus -> hovered_idx stays 0.
// - NUM_CHOICES field 0 = 3'd2: tap right x3 -> field0 0,1,2,0.
//   Same stimulus with WRAP=0 -> field0 0,1,2,2. cmt_choices unchanged throughout.
// - REPEAT_DELAY=10, REPEAT_RATE=4, hold right 30 cycles -> steps at cycles 0,10,14,18,22,26 (6 total).
// - Edit field2 to 1, enter -> commit_pulse for 1 cycle, cmt field2=1.
//   Edit to 0, cancel -> work field2=1, cancel_pulse for 1 cycle.
// - Enter+cancel edges in the same cycle -> cancel_pulse only.
//   Drop enable mid-hold -> IDLE, work reloaded from cmt, no further steps.

Source files
------------

// File: rtl/settings_menu_ctrl.sv
// Settings menu controller: hover navigation, per-option choice editing with
// hold-to-repeat, and commit/cancel of the edited choice set.
module settings_menu_ctrl #(
    parameter int                      NUM_OPTIONS  = 8,
    parameter int                      CW           = 3,
    parameter logic [NUM_OPTIONS*CW-1:0] NUM_CHOICES = {NUM_OPTIONS{CW'(1)}},
    parameter bit                      WRAP         = 1'b1,
    parameter int                      REPEAT_DELAY = 25_000_000,
    parameter int                      REPEAT_RATE  = 5_000_000
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      enable,
    input  logic [9:0]                key_is_pressed,
    input  logic [2:0]                row_idx,
    output logic [2:0]                hovered_idx,
    output logic [NUM_OPTIONS*CW-1:0] work_choices,
    output logic [NUM_OPTIONS*CW-1:0] cmt_choices,
    output logic                      commit_pulse,
    output logic                      cancel_pulse,
    output logic [7:0]                rgb
);

    localparam logic [7:0] BLUE     = 8'h03;
    localparam logic [7:0] WHITE    = 8'hFF;
    localparam logic [2:0] LAST_OPT = 3'(NUM_OPTIONS - 1);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, BROWSE, HOLD} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t           state, state_next;
    dir_t             dir, prev_dir;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             prev_enter, prev_cancel;
    logic             dir_edge, enter_edge, cancel_edge;
    logic             step, active, reload;
    logic             apply_step, commit_fire, cancel_fire;
    logic [2:0]       hover_next;
    logic [NUM_OPTIONS*CW-1:0] work_next;

    // Keypad positions that carry no menu function.
    logic unused_keys;
    assign unused_keys = ^{key_is_pressed[9], key_is_pressed[7],
                           key_is_pressed[3], key_is_pressed[1]};

    function automatic logic [CW-1:0] step_field(input logic [CW-1:0] cur,
                                                 input logic [CW-1:0] lim,
                                                 input logic          inc);
        logic [CW-1:0] res;
        if (inc) begin
            if (cur >= lim) res = WRAP ? '0 : lim;
            else            res = cur + 1'b1;
        end else begin
            if (cur == '0)  res = WRAP ? lim : '0;
            else            res = cur - 1'b1;
        end
        return res;
    endfunction

    always_comb begin
        dir = DIR_NONE;
        if      (key_is_pressed[8]) dir = DIR_UP;
        else if (key_is_pressed[2]) dir = DIR_DOWN;
        else if (key_is_pressed[4]) dir = DIR_LEFT;
        else if (key_is_pressed[6]) dir = DIR_RIGHT;
    end

    // A change of the winning direction counts as a fresh press.
    assign dir_edge    = (dir != DIR_NONE) && (dir != prev_dir);
    assign enter_edge  = key_is_pressed[5] && !prev_enter;
    assign cancel_edge = key_is_pressed[0] && !prev_cancel;

    assign active      = (state != IDLE) && enable;
    assign reload      = (state != IDLE) && !enable;
    assign cancel_fire = active && cancel_edge;
    assign commit_fire = active && enter_edge && !cancel_edge;
    assign apply_step  = step && !enter_edge && !cancel_edge;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        cnt_next   = cnt;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = BROWSE;
            end
            BROWSE: begin
                if (dir_edge) begin
                    step       = 1'b1;
                    state_next = HOLD;
                    cnt_next   = DELAY_LOAD;
                end
            end
            HOLD: begin
                if (dir_edge) begin
                    step     = 1'b1;
                    cnt_next = DELAY_LOAD;
                end else if (dir == DIR_NONE) begin
                    state_next = BROWSE;
                end else if (cnt == '0) begin
                    step     = 1'b1;
                    cnt_next = RATE_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            step       = 1'b0;
        end
    end

    always_comb begin
        hover_next = hovered_idx;
        if (dir == DIR_UP) begin
            if (hovered_idx == 3'd0) hover_next = WRAP ? LAST_OPT : 3'd0;
            else                     hover_next = hovered_idx - 3'd1;
        end else if (dir == DIR_DOWN) begin
            if (hovered_idx >= LAST_OPT) hover_next = WRAP ? 3'd0 : LAST_OPT;
            else                         hover_next = hovered_idx + 3'd1;
        end
    end

    always_comb begin
        work_next = work_choices;
        for (int i = 0; i < NUM_OPTIONS; i++) begin
            if (hovered_idx == 3'(i)) begin
                work_next[i*CW +: CW] = step_field(work_choices[i*CW +: CW],
                                                   NUM_CHOICES[i*CW +: CW],
                                                   dir == DIR_RIGHT);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetN) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_dir    <= DIR_NONE;
            prev_enter  <= 1'b0;
            prev_cancel <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            prev_dir    <= dir;
            prev_enter  <= key_is_pressed[5];
            prev_cancel <= key_is_pressed[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            hovered_idx  <= '0;
            work_choices <= '0;
            cmt_choices  <= '0;
            commit_pulse <= 1'b0;
            cancel_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            cancel_pulse <= 1'b0;
            if (reload) begin
                work_choices <= cmt_choices;
            end else if (cancel_fire) begin
                work_choices <= cmt_choices;
                cancel_pulse <= 1'b1;
            end else if (commit_fire) begin
                cmt_choices  <= work_choices;
                commit_pulse <= 1'b1;
            end else if (apply_step) begin
                if (dir == DIR_UP || dir == DIR_DOWN) hovered_idx  <= hover_next;
                else                                  work_choices <= work_next;
            end
        end
    end

    assign rgb = (row_idx == hovered_idx) ? BLUE : WHITE;

endmodule

// File: tb/tb_settings_menu_ctrl.sv
// Directed bench for settings_menu_ctrl: a wrapping and a saturating instance
// share one stimulus stream and are checked against hand-computed values.
module tb_settings_menu_ctrl;

    localparam logic [23:0] CHOICES = {3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd2};
    localparam logic [9:0] K_UP     = 10'h100;
    localparam logic [9:0] K_DOWN   = 10'h004;
    localparam logic [9:0] K_LEFT   = 10'h010;
    localparam logic [9:0] K_RIGHT  = 10'h040;
    localparam logic [9:0] K_ENTER  = 10'h020;
    localparam logic [9:0] K_CANCEL = 10'h001;
    localparam logic [7:0] BLUE     = 8'h03;
    localparam logic [7:0] WHITE    = 8'hFF;

    logic        clk = 1'b0;
    logic        resetN, enable;
    logic [9:0]  key;
    logic [2:0]  row_idx;
    logic [2:0]  hov_w, hov_s;
    logic [23:0] work_w, work_s, cmt_w, cmt_s;
    logic        cp_w, cp_s, xp_w, xp_s;
    logic [7:0]  rgb_w, rgb_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    settings_menu_ctrl #(.NUM_OPTIONS(8), .CW(3), .NUM_CHOICES(CHOICES), .WRAP(1'b1),
                         .REPEAT_DELAY(10), .REPEAT_RATE(4)) dut_w (
        .clk(clk), .resetN(resetN), .enable(enable), .key_is_pressed(key),
        .row_idx(row_idx), .hovered_idx(hov_w), .work_choices(work_w),
        .cmt_choices(cmt_w), .commit_pulse(cp_w), .cancel_pulse(xp_w), .rgb(rgb_w));

    settings_menu_ctrl #(.NUM_OPTIONS(8), .CW(3), .NUM_CHOICES(CHOICES), .WRAP(1'b0),
                         .REPEAT_DELAY(10), .REPEAT_RATE(4)) dut_s (
        .clk(clk), .resetN(resetN), .enable(enable), .key_is_pressed(key),
        .row_idx(row_idx), .hovered_idx(hov_s), .work_choices(work_s),
        .cmt_choices(cmt_s), .commit_pulse(cp_s), .cancel_pulse(xp_s), .rgb(rgb_s));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [9:0] k);
        key = k;
        tick(1);
        key = '0;
        tick(1);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        enable = 1'b0;
        key    = '0;
        tick(2);
        resetN = 1'b1;
        enable = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        resetN = 1'b0; enable = 1'b0; key = '0; row_idx = 3'd0;
        tick(3);
        checks++;
        if ({hov_w, hov_s} !== 6'd0) begin
            errors++; $display("FAIL reset_hover: got %h/%h expected 0/0", hov_w, hov_s);
        end
        checks++;
        if ({work_w, work_s, cmt_w, cmt_s} !== 96'd0) begin
            errors++; $display("FAIL reset_choices: got %h %h %h %h expected all 0", work_w, work_s, cmt_w, cmt_s);
        end
        checks++;
        if ({cp_w, cp_s, xp_w, xp_s} !== 4'd0) begin
            errors++; $display("FAIL reset_pulses: got %b%b%b%b expected 0000", cp_w, cp_s, xp_w, xp_s);
        end
        checks++;
        if ({rgb_w, rgb_s} !== {BLUE, BLUE}) begin
            errors++; $display("FAIL reset_rgb: got %h/%h expected %h", rgb_w, rgb_s, BLUE);
        end
    endtask

    task automatic test_hover_nav();
        logic [7:0] exp_rgb;
        do_reset();
        repeat (3) tap(K_DOWN);
        checks++;
        if ({hov_w, hov_s} !== {3'd3, 3'd3}) begin
            errors++; $display("FAIL down_x3: got %0d/%0d expected 3/3", hov_w, hov_s);
        end
        for (int r = 0; r < 8; r++) begin
            row_idx = 3'(r);
            #1;
            exp_rgb = (r == 3) ? BLUE : WHITE;
            checks++;
            if ({rgb_w, rgb_s} !== {exp_rgb, exp_rgb}) begin
                errors++; $display("FAIL rgb_row%0d: got %h/%h expected %h", r, rgb_w, rgb_s, exp_rgb);
            end
        end
        row_idx = 3'd0;
        repeat (3) tap(K_UP);
        tap(K_UP);
        checks++;
        if ({hov_w, hov_s} !== {3'd7, 3'd0}) begin
            errors++; $display("FAIL up_at_top: got %0d/%0d expected 7/0", hov_w, hov_s);
        end
        tap(K_DOWN);
        checks++;
        if ({hov_w, hov_s} !== {3'd0, 3'd1}) begin
            errors++; $display("FAIL down_at_bottom: got %0d/%0d expected 0/1", hov_w, hov_s);
        end
    endtask

    task automatic test_choice_step();
        int exp_w[3] = '{1, 2, 0};
        int exp_s[3] = '{1, 2, 2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tap(K_RIGHT);
            checks++;
            if (work_w !== 24'(exp_w[i]) || work_s !== 24'(exp_s[i])) begin
                errors++; $display("FAIL right_%0d: got %h/%h expected %h/%h", i, work_w, work_s, 24'(exp_w[i]), 24'(exp_s[i]));
            end
            checks++;
            if ({cmt_w, cmt_s} !== 48'd0) begin
                errors++; $display("FAIL right_%0d_cmt: got %h/%h expected 0/0", i, cmt_w, cmt_s);
            end
        end
        tap(K_LEFT);
        checks++;
        if (work_w !== 24'd2 || work_s !== 24'd1) begin
            errors++; $display("FAIL left_step: got %h/%h expected 2/1", work_w, work_s);
        end
    endtask

    task automatic test_single_choice();
        do_reset();
        repeat (3) tap(K_DOWN);
        tap(K_RIGHT);
        checks++;
        if ({work_w, work_s} !== 48'd0) begin
            errors++; $display("FAIL single_right: got %h/%h expected 0/0", work_w, work_s);
        end
        tap(K_LEFT);
        checks++;
        if ({work_w, work_s, cp_w, cp_s, xp_w, xp_s} !== 52'd0) begin
            errors++; $display("FAIL single_left: got %h/%h pulses %b%b%b%b expected 0", work_w, work_s, cp_w, cp_s, xp_w, xp_s);
        end
    endtask

    task automatic test_repeat();
        logic [2:0] prev;
        logic       stepped, exp_step;
        do_reset();
        key  = K_DOWN;
        prev = hov_w;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            stepped  = (hov_w != prev);
            exp_step = (k == 0) || (k == 10) || (k == 14) || (k == 18) || (k == 22) || (k == 26);
            prev     = hov_w;
            checks++;
            if (stepped !== exp_step) begin
                errors++; $display("FAIL repeat_cycle%0d: step=%b expected %b", k, stepped, exp_step);
            end
        end
        key = '0;
        tick(10);
        checks++;
        if ({hov_w, hov_s} !== {3'd6, 3'd6}) begin
            errors++; $display("FAIL repeat_total: got %0d/%0d expected 6/6", hov_w, hov_s);
        end
    endtask

    task automatic test_commit_cancel();
        do_reset();
        repeat (2) tap(K_DOWN);
        tap(K_RIGHT);
        checks++;
        if ({work_w, work_s} !== {24'h40, 24'h40}) begin
            errors++; $display("FAIL edit_field2: got %h/%h expected 40/40", work_w, work_s);
        end
        key = K_ENTER;
        tick(1);
        checks++;
        if ({cp_w, cp_s} !== 2'b11 || {cmt_w, cmt_s} !== {24'h40, 24'h40}) begin
            errors++; $display("FAIL commit: pulse %b%b cmt %h/%h expected 11 40/40", cp_w, cp_s, cmt_w, cmt_s);
        end
        tick(1);
        checks++;
        if ({cp_w, cp_s} !== 2'b00) begin
            errors++; $display("FAIL commit_width: got %b%b expected 00", cp_w, cp_s);
        end
        key = '0;
        tick(1);
        tap(K_LEFT);
        key = K_CANCEL;
        tick(1);
        checks++;
        if ({xp_w, xp_s} !== 2'b11 || {work_w, work_s} !== {24'h40, 24'h40} || {cp_w, cp_s} !== 2'b00) begin
            errors++; $display("FAIL cancel: pulse %b%b commit %b%b work %h/%h expected 11 00 40/40", xp_w, xp_s, cp_w, cp_s, work_w, work_s);
        end
        tick(1);
        checks++;
        if ({xp_w, xp_s} !== 2'b00) begin
            errors++; $display("FAIL cancel_width: got %b%b expected 00", xp_w, xp_s);
        end
        key = '0;
        tick(1);
    endtask

    task automatic test_enter_cancel_same();
        tap(K_LEFT);
        key = K_ENTER | K_CANCEL;
        tick(1);
        checks++;
        if ({xp_w, xp_s, cp_w, cp_s} !== 4'b1100 || {cmt_w, cmt_s} !== {24'h40, 24'h40}
            || {work_w, work_s} !== {24'h40, 24'h40}) begin
            errors++; $display("FAIL enter_cancel_same: pulses %b%b%b%b cmt %h/%h work %h/%h expected 1100 40 40",
                               xp_w, xp_s, cp_w, cp_s, cmt_w, cmt_s, work_w, work_s);
        end
        key = '0;
        tick(1);
    endtask

    task automatic test_step_with_key();
        tap(K_LEFT);
        key = K_DOWN | K_ENTER;
        tick(1);
        checks++;
        if ({cp_w, cp_s} !== 2'b11 || {hov_w, hov_s} !== {3'd2, 3'd2} || {cmt_w, cmt_s} !== 48'd0) begin
            errors++; $display("FAIL step_with_enter: pulse %b%b hov %0d/%0d cmt %h/%h expected 11 2/2 0/0",
                               cp_w, cp_s, hov_w, hov_s, cmt_w, cmt_s);
        end
        key = '0;
        tick(1);
        tap(K_RIGHT);
        key = K_RIGHT | K_CANCEL;
        tick(1);
        checks++;
        if ({xp_w, xp_s} !== 2'b11 || {work_w, work_s} !== 48'd0) begin
            errors++; $display("FAIL step_with_cancel: pulse %b%b work %h/%h expected 11 0/0", xp_w, xp_s, work_w, work_s);
        end
        key = '0;
        tick(1);
    endtask

    task automatic test_enable_drop();
        tap(K_RIGHT);
        key = K_DOWN;
        tick(1);
        checks++;
        if ({hov_w, hov_s} !== {3'd3, 3'd3}) begin
            errors++; $display("FAIL hold_start: got %0d/%0d expected 3/3", hov_w, hov_s);
        end
        tick(3);
        enable = 1'b0;
        tick(1);
        checks++;
        if ({work_w, work_s} !== 48'd0) begin
            errors++; $display("FAIL idle_reload: got %h/%h expected 0/0", work_w, work_s);
        end
        tick(20);
        checks++;
        if ({hov_w, hov_s} !== {3'd3, 3'd3}) begin
            errors++; $display("FAIL disabled_hold: got %0d/%0d expected 3/3", hov_w, hov_s);
        end
        enable = 1'b1;
        tick(20);
        checks++;
        if ({hov_w, hov_s} !== {3'd3, 3'd3}) begin
            errors++; $display("FAIL held_at_enable: got %0d/%0d expected 3/3", hov_w, hov_s);
        end
        key = '0;
        tick(1);
    endtask

    task automatic test_reset_mid_hold();
        key = K_DOWN;
        tick(1);
        checks++;
        if ({hov_w, hov_s} !== {3'd4, 3'd4}) begin
            errors++; $display("FAIL prehold: got %0d/%0d expected 4/4", hov_w, hov_s);
        end
        tick(5);
        resetN = 1'b0;
        tick(1);
        resetN = 1'b1;
        checks++;
        if ({hov_w, hov_s} !== 6'd0 || {work_w, work_s, cmt_w, cmt_s} !== 96'd0) begin
            errors++; $display("FAIL reset_in_hold: hov %0d/%0d work %h/%h expected 0", hov_w, hov_s, work_w, work_s);
        end
        tick(20);
        checks++;
        if ({hov_w, hov_s} !== 6'd0) begin
            errors++; $display("FAIL stale_repeat: got %0d/%0d expected 0/0", hov_w, hov_s);
        end
        key = '0;
        tick(1);
    endtask

    initial begin
        resetN = 1'b0; enable = 1'b0; key = '0; row_idx = 3'd0;
        test_reset();
        test_hover_nav();
        test_choice_step();
        test_single_choice();
        test_repeat();
        test_commit_cancel();
        test_enter_cancel_same();
        test_step_with_key();
        test_enable_drop();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
